// File: rtl/beat_sequencer.sv
// Machine-beat generator for the hardwired CPU controller: one-hot W1/W2/W3 beats,
// run/halt control from the start button, stop and single-step, and a completed-cycle counter.
//
// state | meaning
// ------+---------------------------------------------------------------
// HALT  | beat register frozen; waiting for a synchronised qd rising edge
// RUN   | beat advances on every t3; cycle completions counted
module beat_sequencer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic             cyc_end,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] BEAT_W1 = 3'b001;
    localparam logic [2:0] BEAT_W2 = 3'b010;
    localparam logic [2:0] BEAT_W3 = 3'b100;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   qd_prev_q;
    state_t                 state_q;
    logic [2:0]             beat_q;
    logic [2:0]             beat_d;
    logic                   cyc_end_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   qd_rise;
    logic                   complete;

    assign qd_rise = sync_q[SYNC_STAGES-1] & ~qd_prev_q;

    // Next beat while running; a cycle completes whenever the next beat is W1.
    always_comb begin
        beat_d   = BEAT_W1;
        complete = 1'b0;
        case (beat_q)
            BEAT_W1: begin
                if (short) begin
                    beat_d   = BEAT_W1;
                    complete = 1'b1;
                end else begin
                    beat_d = BEAT_W2;
                end
            end
            BEAT_W2: begin
                if (long) begin
                    beat_d = BEAT_W3;
                end else begin
                    beat_d   = BEAT_W1;
                    complete = 1'b1;
                end
            end
            default: begin
                beat_d   = BEAT_W1;
                complete = 1'b1;
            end
        endcase
    end

    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            sync_q    <= '0;
            qd_prev_q <= 1'b0;
            state_q   <= HALT;
            beat_q    <= BEAT_W1;
            cyc_end_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], qd};
            qd_prev_q <= sync_q[SYNC_STAGES-1];
            case (state_q)
                HALT: begin
                    cyc_end_q <= 1'b0;
                    if (qd_rise) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // The beat advances even on the halting edge so a resumed run continues.
                    beat_q    <= beat_d;
                    cyc_end_q <= complete;
                    if (complete) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (stop || (step_mode && complete)) begin
                        state_q <= HALT;
                    end
                end
                default: begin
                    state_q   <= HALT;
                    cyc_end_q <= 1'b0;
                end
            endcase
        end
    end

    assign w1        = beat_q[0];
    assign w2        = beat_q[1];
    assign w3        = beat_q[2];
    assign running   = (state_q == RUN);
    assign cyc_end   = cyc_end_q;
    assign instr_cnt = cnt_q;

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
- Timing generator for the hardwired CPU controller.
- Produces the one-hot machine beats w1/w2/w3 that the controller decodes.
- Honours the controller's short/long/stop outputs, starts on the front-panel start button (qd), and supports single-instruction stepping.
- Sits between the panel/clock source and the controller. Its beat outputs feed the controller's w1/w2/w3 inputs directly.

Parameters:
- CNT_W, 16, width of the completed-instruction counter.
- SYNC_STAGES, 2, synchroniser depth for qd (minimum 2).

Ports:
- t3  input  1  system clock (beat-end pulse); all state changes on posedge t3.
- clr  input  1  asynchronous active-low reset.
- qd  input  1  start push-button, asynchronous, active-high.
- step_mode  input  1  1 = halt after each completed instruction.
- short  input  1  from controller: current cycle ends after W1.
- long  input  1  from controller: current cycle extends to W3.
- stop  input  1  from controller: halt after the current beat.
- w1  output  1  beat 1 active.
- w2  output  1  beat 2 active.
- w3  output  1  beat 3 active.
- running  output  1  sequencer in RUN state.
- cyc_end  output  1  one-t3 pulse registered when a cycle completes in RUN.
- instr_cnt  output  CNT_W  completed-cycle count, wraps modulo 2^CNT_W.

Behaviour:
- Reset (clr=0, async):
  - beat=W1 (w1=1, w2=w3=0), state=HALT, running=0, cyc_end=0, instr_cnt=0.
  - Synchroniser flops and qd edge-detect history cleared.
  - Reset mid-cycle discards the partial cycle; no count and no cyc_end.
- Beat outputs are registered and exactly one-hot at all times after reset.
- qd handling: qd passes through SYNC_STAGES flops, then a rising-edge detector. qd_rise is a one-t3 pulse per press. Holding qd high gives a single pulse.
- States:
  - HALT: beat register holds its value.
    - qd_rise -> RUN on the next t3. The beat is unchanged, so execution resumes at the held beat.
    - stop, short and long are ignored while in HALT.
  - RUN: every t3 advances the beat:
    - W1: short=1 -> W1 (cycle complete); else -> W2.
    - W2: long=1 -> W3; else -> W1 (cycle complete).
    - W3: -> W1 (cycle complete); short and long ignored.
    - short and long are sampled only in the beats listed above. short=long=1 in W1 behaves as short.
  - RUN -> HALT at the same t3 edge if either:
    - stop=1, in any beat, or
    - step_mode=1 and the edge completes a cycle.
  - Either way the beat still advances at that edge, so a resumed run starts at the next beat.
  - qd_rise while in RUN is ignored.
- Cycle completion ("complete" above) is any RUN edge whose next beat is W1.
  - cyc_end=1 for exactly the following t3 period; otherwise 0.
  - instr_cnt increments by 1 at that edge; all-ones wraps to 0.
- stop together with a completing edge: the count and cyc_end still occur, and the state goes to HALT.
- running = (state==RUN), registered.

Test Plan:
- Reset, then clr=1 with no qd for 10 t3 -> w1=1, running=0, instr_cnt=0 throughout.
- qd pulse, short=long=stop=0, step_mode=0 -> after sync latency running=1; beats W1,W2,W1,W2,...; instr_cnt increments every 2 t3; cyc_end pulses after each W2.
- long=1 while in W2 -> sequence W1,W2,W3,W1; one count per 3 t3. short=1 in W1 -> w1 held; count increments every t3.
- stop=1 during W2 of a long cycle -> at that edge running=0 and beat=W3 held. Next qd press -> W3 executes, then W1, with count +1.
- step_mode=1, running a 2-beat cycle -> halts with w1=1 after each cycle, instr_cnt +1 per qd press. Holding qd high for 20 t3 advances only one cycle.
- clr pulsed low during W3 with instr_cnt=5 -> immediately w1=1, running=0, instr_cnt=0, cyc_end=0. With CNT_W=2, after 4 cycles instr_cnt wraps 3->0.
